// File: rtl/stack_sequencer.sv
// Command sequencer for an external stack: turns PUSH/POP/DUP/TOS/ALU opcodes into stack strobes.
// Optional depth checking (underflow/overflow rejection) is enabled by defining STACK_SEQ_DEPTH_CHECK_EN.
module stack_sequencer #(
  parameter int W     = 8,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  input  logic [2:0]               cmd_op,
  input  logic [W-1:0]             cmd_imm,
  output logic                     cmd_ready,
  output logic                     st_push,
  output logic                     st_pop,
  output logic                     st_tos,
  output logic [W-1:0]             st_din,
  input  logic [W-1:0]             st_dout,
  output logic                     rsp_valid,
  output logic [W-1:0]             rsp_data,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH):0]   depth
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_DUP  = 3'b010;
  localparam logic [2:0] OP_TOS  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    CAP1,
    RD2,
    CAP2,
    WR,
    RSP
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [2:0]     op_q;
  logic [W-1:0]   imm_q;
  logic [W-1:0]   t_q;
  logic [W-1:0]   n_q;
  logic [W-1:0]   res_q;
  logic [W-1:0]   wr_data;
  logic           reject;
  logic           accept;
  logic           op_binary;
  logic           op_read_only;
  logic           op_peek;

  assign cmd_ready    = (state == IDLE);
  assign accept       = cmd_valid && cmd_ready;
  assign rsp_valid    = (state == RSP);
  assign rsp_data     = res_q;
  assign op_binary    = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND);
  assign op_read_only = (op_q == OP_POP) || (op_q == OP_TOS);
  assign op_peek      = (op_q == OP_TOS) || (op_q == OP_DUP);

`ifdef STACK_SEQ_DEPTH_CHECK_EN
  logic err_q;

  // Rejection is decided on the live opcode and depth at accept time.
  always_comb begin
    reject = 1'b0;
    case (cmd_op)
      OP_POP, OP_TOS, OP_NOT: reject = (depth == '0);
      OP_DUP:                 reject = (depth == '0) || (depth == DEPTH_MAX);
      OP_ADD, OP_SUB, OP_AND: reject = (depth < DW'(2));
      OP_PUSH:                reject = (depth == DEPTH_MAX);
      default:                reject = 1'b0;
    endcase
  end

  assign rsp_err = rsp_valid && err_q;
`else
  assign reject  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    wr_data = t_q;
    case (op_q)
      OP_PUSH: wr_data = imm_q;
      OP_DUP:  wr_data = t_q;
      OP_NOT:  wr_data = ~t_q;
      OP_ADD:  wr_data = n_q + t_q;
      OP_SUB:  wr_data = n_q - t_q;
      OP_AND:  wr_data = n_q & t_q;
      default: wr_data = t_q;
    endcase
  end

  // Binary ops issue their second pop from CAP1 so the first operand capture overlaps it.
  always_comb begin
    state_nxt = state;
    st_push   = 1'b0;
    st_pop    = 1'b0;
    st_tos    = 1'b0;
    st_din    = '0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (reject)                 state_nxt = RSP;
          else if (cmd_op == OP_PUSH) state_nxt = WR;
          else                        state_nxt = RD1;
        end
      end
      RD1: begin
        if (op_peek) st_tos = 1'b1;
        else         st_pop = 1'b1;
        state_nxt = CAP1;
      end
      CAP1: begin
        if (op_binary) begin
          st_pop    = 1'b1;
          state_nxt = CAP2;
        end else if (op_read_only) begin
          state_nxt = RSP;
        end else begin
          state_nxt = WR;
        end
      end
      RD2: begin
        st_pop    = 1'b1;
        state_nxt = CAP2;
      end
      CAP2: state_nxt = WR;
      WR: begin
        st_push   = 1'b1;
        st_din    = wr_data;
        state_nxt = RSP;
      end
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      imm_q <= '0;
      t_q   <= '0;
      n_q   <= '0;
      res_q <= '0;
`ifdef STACK_SEQ_DEPTH_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q  <= cmd_op;
        imm_q <= cmd_imm;
`ifdef STACK_SEQ_DEPTH_CHECK_EN
        err_q <= reject;
`endif
        if (reject) res_q <= '0;
      end
      if (state == CAP1) begin
        t_q <= st_dout;
        if (op_read_only) res_q <= st_dout;
      end
      if (state == CAP2) n_q <= st_dout;
      if (state == WR)   res_q <= wr_data;
    end
  end

  // Entry count saturates at both ends so an unchecked build never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
    end else if (st_push && (depth != DEPTH_MAX)) begin
      depth <= depth + DW'(1);
    end else if (st_pop && (depth != '0)) begin
      depth <= depth - DW'(1);
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer with a behavioural stack attached to the strobe interface.
module tb_stack_sequencer;

  localparam int W     = 8;
  localparam int DEPTH = 256;
  localparam int DW    = 9;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_DUP  = 3'b010;
  localparam logic [2:0] OP_TOS  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic [2:0]    cmd_op;
  logic [W-1:0]  cmd_imm;
  logic          cmd_ready;
  logic          st_push;
  logic          st_pop;
  logic          st_tos;
  logic [W-1:0]  st_din;
  logic [W-1:0]  st_dout;
  logic          rsp_valid;
  logic [W-1:0]  rsp_data;
  logic          rsp_err;
  logic [DW-1:0] depth;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           lat;
    int           acc;
    int           tag;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tag_cnt = 0;
  int push_cnt = 0;
  int pop_cnt = 0;
  int tos_cnt = 0;
  int rsp_cnt = 0;
  int viol_cnt = 0;

  logic [W-1:0] mem [0:DEPTH];
  int sp;

  always #5 clk = ~clk;

  stack_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_imm   (cmd_imm),
    .cmd_ready (cmd_ready),
    .st_push   (st_push),
    .st_pop    (st_pop),
    .st_tos    (st_tos),
    .st_din    (st_din),
    .st_dout   (st_dout),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .depth     (depth)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stack: read data appears the cycle after pop/tos; empty reads return zero.
  always @(posedge clk) begin
    if (rst) begin
      sp      <= 0;
      st_dout <= '0;
    end else if (st_push) begin
      if (sp <= DEPTH) mem[sp] <= st_din;
      if (sp < DEPTH) sp <= sp + 1;
    end else if (st_pop) begin
      if (sp > 0) begin
        st_dout <= mem[sp-1];
        sp      <= sp - 1;
      end else begin
        st_dout <= '0;
      end
    end else if (st_tos) begin
      st_dout <= (sp > 0) ? mem[sp-1] : '0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: strobe bookkeeping plus scoreboard pop on every response pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (st_push) push_cnt++;
      if (st_pop)  pop_cnt++;
      if (st_tos)  tos_cnt++;
      if ((int'(st_push) + int'(st_pop) + int'(st_tos)) > 1) viol_cnt++;
      if (cmd_ready && (st_push || st_pop || st_tos)) viol_cnt++;
      if (rsp_valid) begin
        rsp_cnt++;
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_rsp: got rsp_data 0x%0h with no command outstanding, expected none", rsp_data);
        end else begin
          mon_e = sbq.pop_front();
          checkOutput($sformatf("rsp_data#%0d", mon_e.tag), 32'(rsp_data), 32'(mon_e.data));
          checkOutput($sformatf("rsp_err#%0d", mon_e.tag), 32'(rsp_err), 32'(mon_e.err));
          checkOutput($sformatf("latency#%0d", mon_e.tag), 32'(cyc - mon_e.acc), 32'(mon_e.lat));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] imm,
                               input logic [W-1:0] exp_data, input logic exp_err, input int exp_lat);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL ready_timeout: got cmd_ready=0 for 100 cycles, expected 1");
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_imm   = imm;
    e.data = exp_data;
    e.err  = exp_err;
    e.lat  = exp_lat;
    e.acc  = cyc;
    e.tag  = tag_cnt;
    tag_cnt++;
    sbq.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_imm   = W'($urandom);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || !cmd_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0 || !cmd_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL idle_timeout: got %0d responses outstanding, expected 0", sbq.size());
    end
  endtask

  task automatic doReset();
    cmd_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0;
    int u0;
    int r0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_imm   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_data",  32'(rsp_data),  32'd0);
    checkOutput("reset_rsp_err",   32'(rsp_err),   32'd0);
    checkOutput("reset_depth",     32'(depth),     32'd0);
    checkOutput("reset_strobes",   32'({st_push, st_pop, st_tos}), 32'd0);
    checkOutput("reset_st_din",    32'(st_din),    32'd0);
    rst = 1'b0;

    // Push and add
    p0 = pop_cnt;
    applyStimulus(OP_PUSH, 8'h05, 8'h05, 1'b0, 2);
    applyStimulus(OP_PUSH, 8'h03, 8'h03, 1'b0, 2);
    applyStimulus(OP_ADD,  8'h00, 8'h08, 1'b0, 5);
    waitIdle();
    checkOutput("add_depth", 32'(depth), 32'd1);
    checkOutput("add_pops",  32'(pop_cnt - p0), 32'd2);

    // Subtract with borrow, add with carry
    doReset();
    applyStimulus(OP_PUSH, 8'h02, 8'h02, 1'b0, 2);
    applyStimulus(OP_PUSH, 8'h05, 8'h05, 1'b0, 2);
    applyStimulus(OP_SUB,  8'h00, 8'hFD, 1'b0, 5);
    applyStimulus(OP_PUSH, 8'hFF, 8'hFF, 1'b0, 2);
    applyStimulus(OP_ADD,  8'h00, 8'hFC, 1'b0, 5);
    waitIdle();
    checkOutput("sub_depth", 32'(depth), 32'd1);

    // AND followed by a non-destructive TOS
    doReset();
    u0 = tos_cnt;
    applyStimulus(OP_PUSH, 8'hF0, 8'hF0, 1'b0, 2);
    applyStimulus(OP_PUSH, 8'h3C, 8'h3C, 1'b0, 2);
    applyStimulus(OP_AND,  8'h00, 8'h30, 1'b0, 5);
    applyStimulus(OP_TOS,  8'h00, 8'h30, 1'b0, 3);
    waitIdle();
    checkOutput("tos_depth",   32'(depth), 32'd1);
    checkOutput("tos_strobes", 32'(tos_cnt - u0), 32'd1);

    // DUP, NOT, POP, POP
    doReset();
    applyStimulus(OP_PUSH, 8'hA5, 8'hA5, 1'b0, 2);
    applyStimulus(OP_DUP,  8'h00, 8'hA5, 1'b0, 4);
    applyStimulus(OP_NOT,  8'h00, 8'h5A, 1'b0, 4);
    applyStimulus(OP_POP,  8'h00, 8'h5A, 1'b0, 3);
    applyStimulus(OP_POP,  8'h00, 8'hA5, 1'b0, 3);
    waitIdle();
    checkOutput("pop_depth", 32'(depth), 32'd0);

    // ADD on an empty stack
    doReset();
    p0 = pop_cnt;
    u0 = push_cnt;
`ifdef STACK_SEQ_DEPTH_CHECK_EN
    applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b1, 1);
    waitIdle();
    checkOutput("under_pops",   32'(pop_cnt - p0), 32'd0);
    checkOutput("under_pushes", 32'(push_cnt - u0), 32'd0);
    checkOutput("under_depth",  32'(depth), 32'd0);
`else
    applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b0, 5);
    waitIdle();
    checkOutput("under_pops",   32'(pop_cnt - p0), 32'd2);
    checkOutput("under_pushes", 32'(push_cnt - u0), 32'd1);
    checkOutput("under_depth",  32'(depth), 32'd1);
`endif

`ifdef STACK_SEQ_DEPTH_CHECK_EN
    // Fill to capacity, then overflow attempts
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(OP_PUSH, W'(i), W'(i), 1'b0, 2);
    end
    waitIdle();
    checkOutput("full_depth", 32'(depth), 32'd256);
    u0 = push_cnt;
    applyStimulus(OP_PUSH, 8'h11, 8'h00, 1'b1, 1);
    applyStimulus(OP_DUP,  8'h00, 8'h00, 1'b1, 1);
    applyStimulus(OP_TOS,  8'h00, 8'hFF, 1'b0, 3);
    waitIdle();
    checkOutput("over_pushes", 32'(push_cnt - u0), 32'd0);
    checkOutput("over_depth",  32'(depth), 32'd256);
`endif

    // Reset during CAP1 of an ADD
    doReset();
    applyStimulus(OP_PUSH, 8'h01, 8'h01, 1'b0, 2);
    applyStimulus(OP_PUSH, 8'h02, 8'h02, 1'b0, 2);
    waitIdle();
    r0 = rsp_cnt;
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    cmd_imm   = 8'h00;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_cap1_pop", 32'(st_pop), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_depth",     32'(depth), 32'd0);
    checkOutput("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("abort_strobes",   32'({st_push, st_pop, st_tos}), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("abort_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    applyStimulus(OP_PUSH, 8'h07, 8'h07, 1'b0, 2);
    applyStimulus(OP_POP,  8'h00, 8'h07, 1'b0, 3);
    waitIdle();
    checkOutput("recover_depth", 32'(depth), 32'd0);

    checkOutput("strobe_rule_violations", 32'(viol_cnt), 32'd0);
    checkOutput("pending_responses", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
